// File: rtl/dadda_pkg.sv
// Shared definitions for the Dadda multiplier datapath: operand/product widths,
// the product type, and the counter-width helper used by the accumulator.
package dadda_pkg;

  localparam int unsigned OP_W   = 8;
  localparam int unsigned PROD_W = 16;

  typedef logic [PROD_W-1:0] prod_t;

  // Width of a 0..len-1 counter; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned len);
    return (len <= 2) ? 1 : $clog2(len);
  endfunction

endpackage

// File: rtl/dadda_dot_accum_dadda.sv
// 8x8 unsigned Dadda multiplier: partial-product rows reduced 8->6->4->3->2
// with carry-save stages, then a single carry-propagate add.
module DADDA_8x8
  import dadda_pkg::*;
(
  input  logic [OP_W-1:0] a,
  input  logic [OP_W-1:0] b,
  output prod_t           out
);

  prod_t pp [OP_W];
  prod_t s1 [6];
  prod_t s2 [4];
  prod_t s3 [3];
  prod_t s4 [2];

  function automatic prod_t csa_sum(input prod_t x, input prod_t y, input prod_t z);
    return x ^ y ^ z;
  endfunction

  // Carry dropped out of bit 15 has weight 2^16, so every row pair stays exact mod 2^16.
  function automatic prod_t csa_carry(input prod_t x, input prod_t y, input prod_t z);
    return ((x & y) | (x & z) | (y & z)) << 1;
  endfunction

  always_comb begin
    for (int unsigned i = 0; i < OP_W; i++) begin
      pp[i] = prod_t'(a & {OP_W{b[i]}}) << i;
    end
  end

  always_comb begin
    s1[0] = csa_sum  (pp[0], pp[1], pp[2]);
    s1[1] = csa_carry(pp[0], pp[1], pp[2]);
    s1[2] = csa_sum  (pp[3], pp[4], pp[5]);
    s1[3] = csa_carry(pp[3], pp[4], pp[5]);
    s1[4] = pp[6];
    s1[5] = pp[7];

    s2[0] = csa_sum  (s1[0], s1[1], s1[2]);
    s2[1] = csa_carry(s1[0], s1[1], s1[2]);
    s2[2] = csa_sum  (s1[3], s1[4], s1[5]);
    s2[3] = csa_carry(s1[3], s1[4], s1[5]);

    s3[0] = csa_sum  (s2[0], s2[1], s2[2]);
    s3[1] = csa_carry(s2[0], s2[1], s2[2]);
    s3[2] = s2[3];

    s4[0] = csa_sum  (s3[0], s3[1], s3[2]);
    s4[1] = csa_carry(s3[0], s3[1], s3[2]);

    out = s4[0] + s4[1];
  end

endmodule

// File: rtl/dadda_dot_accum.sv
// Pipelined dot-product accumulator around DADDA_8x8 with valid/ready on both sides.
// Define DOT_SAT_EN to saturate on overflow; otherwise sums wrap modulo 2^ACC_W.
module dadda_dot_accum
  import dadda_pkg::*;
#(
  parameter int unsigned LEN   = 4,
  parameter int unsigned ACC_W = 18
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_a,
  input  logic [OP_W-1:0]  in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf
);

  localparam int unsigned      CNT_W    = cnt_width(LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LEN - 1);

  prod_t            mult;
  logic [CNT_W-1:0] cnt;
  logic [ACC_W-1:0] p_reg;
  logic             p_valid;
  logic             p_last;
  logic [ACC_W-1:0] acc;
  logic             ovf_sticky;
  logic             stall;
  logic             accept;
  logic [ACC_W:0]   add_full;
  logic             carry;
  logic [ACC_W-1:0] add_res;

  DADDA_8x8 u_mult (
    .a   (in_a),
    .b   (in_b),
    .out (mult)
  );

  // Only a finished vector blocked by an unread result freezes the pipe.
  assign stall    = p_valid && p_last && out_valid && !out_ready;
  assign in_ready = !stall;
  assign accept   = in_valid && in_ready;

  always_comb begin
    add_full = {1'b0, acc} + {1'b0, p_reg};
    carry    = add_full[ACC_W];
`ifdef DOT_SAT_EN
    add_res  = (carry || ovf_sticky) ? '1 : add_full[ACC_W-1:0];
`else
    add_res  = add_full[ACC_W-1:0];
`endif
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt     <= '0;
      p_reg   <= '0;
      p_valid <= 1'b0;
      p_last  <= 1'b0;
    end else if (!stall) begin
      if (accept) begin
        p_reg   <= ACC_W'(mult);
        p_valid <= 1'b1;
        p_last  <= (cnt == CNT_LAST);
        cnt     <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
      end else begin
        p_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc        <= '0;
      ovf_sticky <= 1'b0;
      out_valid  <= 1'b0;
      out_sum    <= '0;
      out_ovf    <= 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      // A completing vector overrides the drop above, so results can issue back to back.
      if (p_valid && !stall) begin
        if (p_last) begin
          out_sum    <= add_res;
          out_ovf    <= ovf_sticky || carry;
          out_valid  <= 1'b1;
          acc        <= '0;
          ovf_sticky <= 1'b0;
        end else begin
          acc        <= add_res;
          ovf_sticky <= ovf_sticky || carry;
        end
      end
    end
  end

endmodule

// File: tb/tb_dadda_dot_accum.sv
// Self-checking bench for dadda_dot_accum: directed vector table, multi-cycle
// corner sequences, and randomized traffic against a plain-arithmetic model.
module tb_dadda_dot_accum;

  localparam int unsigned LEN = 4;
  localparam int unsigned W_A = 18;
  localparam int unsigned W_B = 17;
`ifdef DOT_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clock   = 1'b0;
  logic reset_n = 1'b1;

  logic           a_in_valid = 1'b0;
  logic           a_in_ready;
  logic [7:0]     a_in_a = '0;
  logic [7:0]     a_in_b = '0;
  logic           a_out_valid;
  logic           a_out_ready = 1'b1;
  logic [W_A-1:0] a_out_sum;
  logic           a_out_ovf;

  logic           b_in_valid = 1'b0;
  logic           b_in_ready;
  logic [7:0]     b_in_a = '0;
  logic [7:0]     b_in_b = '0;
  logic           b_out_valid;
  logic           b_out_ready = 1'b1;
  logic [W_B-1:0] b_out_sum;
  logic           b_out_ovf;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clock = ~clock;

  dadda_dot_accum #(.LEN(LEN), .ACC_W(W_A)) dut_a (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .in_a      (a_in_a),
    .in_b      (a_in_b),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .out_sum   (a_out_sum),
    .out_ovf   (a_out_ovf)
  );

  dadda_dot_accum #(.LEN(LEN), .ACC_W(W_B)) dut_b (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .in_a      (b_in_a),
    .in_b      (b_in_b),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .out_sum   (b_out_sum),
    .out_ovf   (b_out_ovf)
  );

  typedef struct {
    bit          sel;
    logic [31:0] a;
    logic [31:0] b;
    bit          gap;
    int unsigned sum;
    bit          ovf;
    string       name;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input bit sel, input logic v, input logic [7:0] a, input logic [7:0] b);
    if (sel) begin
      b_in_valid = v; b_in_a = a; b_in_b = b;
    end else begin
      a_in_valid = v; a_in_a = a; a_in_b = b;
    end
  endtask

  function automatic logic [31:0] sum_of(input bit sel);
    return sel ? 32'(b_out_sum) : 32'(a_out_sum);
  endfunction
  function automatic logic valid_of(input bit sel);
    return sel ? b_out_valid : a_out_valid;
  endfunction
  function automatic logic ovf_of(input bit sel);
    return sel ? b_out_ovf : a_out_ovf;
  endfunction
  function automatic logic ready_of(input bit sel);
    return sel ? b_in_ready : a_in_ready;
  endfunction

  // Sends one vector (optionally with idle cycles between pairs) and checks
  // that the result appears exactly one cycle after the last pair leaves P.
  task automatic run_vec(input vec_t v);
    for (int k = 0; k < LEN; k++) begin
      drive(v.sel, 1'b1, v.a[8*k +: 8], v.b[8*k +: 8]);
      @(negedge clock);
      check({v.name, "/in_ready"}, ready_of(v.sel), 1);
      next_cycle();
      if (v.gap && k != LEN - 1) begin
        drive(v.sel, 1'b0, 8'hAA, 8'h55);
        next_cycle();
      end
    end
    drive(v.sel, 1'b0, 8'h00, 8'h00);
    @(negedge clock);
    check({v.name, "/valid_early"}, valid_of(v.sel), 0);
    next_cycle();
    @(negedge clock);
    check({v.name, "/valid"}, valid_of(v.sel), 1);
    check({v.name, "/sum"}, sum_of(v.sel), v.sum);
    check({v.name, "/ovf"}, ovf_of(v.sel), v.ovf);
    next_cycle();
    @(negedge clock);
    check({v.name, "/valid_drop"}, valid_of(v.sel), 0);
    next_cycle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[8];
    vec_t post_rst;
    int unsigned res_cnt, ir_low, first_at, second_at, accepts, hs;
    int drop_at;
    logic valid_at1;
    int unsigned q_sum[$];
    bit          q_ovf[$];
    int unsigned remaining, part, pcnt, ra, rb, max_b;

    vecs[0] = '{sel:1'b0, a:32'h07050301, b:32'h08060402, gap:1'b0, sum:100,    ovf:1'b0, name:"basic"};
    vecs[1] = '{sel:1'b0, a:32'hFFFFFFFF, b:32'hFFFFFFFF, gap:1'b0, sum:260100, ovf:1'b0, name:"max18"};
    vecs[2] = '{sel:1'b0, a:32'h02010900, b:32'h02010009, gap:1'b1, sum:5,      ovf:1'b0, name:"idle_gaps"};
    vecs[3] = '{sel:1'b0, a:32'h01003264, b:32'hFF0032C8, gap:1'b0, sum:22755,  ovf:1'b0, name:"mixed"};
    vecs[4] = '{sel:1'b1, a:32'hFFFFFFFF, b:32'hFFFFFFFF, gap:1'b0,
                sum:(SAT ? 131071 : 129028), ovf:1'b1, name:"ovf17"};
    vecs[5] = '{sel:1'b1, a:32'h03FAFFFF, b:32'h0704FFFF, gap:1'b0, sum:131071, ovf:1'b0, name:"exact_max17"};
    vecs[6] = '{sel:1'b1, a:32'h02FAFFFF, b:32'h0B04FFFF, gap:1'b0,
                sum:(SAT ? 131071 : 0), ovf:1'b1, name:"just_over17"};
    vecs[7] = '{sel:1'b1, a:32'h00FFFFFF, b:32'h00FFFFFF, gap:1'b1,
                sum:(SAT ? 131071 : 64003), ovf:1'b1, name:"early_ovf17"};
    post_rst = '{sel:1'b0, a:32'h02020202, b:32'h03030303, gap:1'b0, sum:24, ovf:1'b0, name:"post_reset"};

    // Reset state
    #1 reset_n = 1'b0;
    #1;
    check("reset/out_valid", a_out_valid, 0);
    check("reset/out_sum", a_out_sum, 0);
    check("reset/out_ovf", a_out_ovf, 0);
    check("reset/in_ready", a_in_ready, 1);
    next_cycle();
    next_cycle();
    reset_n = 1'b1;
    next_cycle();

    for (int unsigned i = 0; i < 8; i++) run_vec(vecs[i]);

    // Back-to-back vectors at full rate
    res_cnt = 0; ir_low = 0; first_at = 0; second_at = 0;
    for (int unsigned c = 0; c < 14; c++) begin
      drive(1'b0, c < 8, 8'd255, 8'd255);
      @(negedge clock);
      if (!a_in_ready) ir_low++;
      if (a_out_valid && a_out_ready) begin
        check("b2b/sum", a_out_sum, 260100);
        check("b2b/ovf", a_out_ovf, 0);
        if (res_cnt == 0) first_at = c; else second_at = c;
        res_cnt++;
      end
      next_cycle();
    end
    check("b2b/count", res_cnt, 2);
    check("b2b/in_ready_low_cycles", ir_low, 0);
    check("b2b/first_cycle", first_at, 5);
    check("b2b/spacing", second_at - first_at, LEN);

    // Backpressure across two vectors of (1,1)
    a_out_ready = 1'b0;
    accepts = 0; drop_at = -1;
    for (int c = 0; c < 16; c++) begin
      drive(1'b0, accepts < 8, 8'd1, 8'd1);
      @(negedge clock);
      if (a_in_valid && a_in_ready) accepts++;
      if (!a_in_ready && drop_at < 0) drop_at = c;
      if (a_out_valid) check("bp/held_sum", a_out_sum, 4);
      next_cycle();
    end
    check("bp/accepts", accepts, 8);
    check("bp/in_ready_drop_cycle", drop_at, 8);
    check("bp/in_ready_held_low", a_in_ready, 0);
    a_out_ready = 1'b1;
    hs = 0; valid_at1 = 1'b0;
    for (int unsigned c = 0; c < 6; c++) begin
      drive(1'b0, 1'b0, 8'd0, 8'd0);
      @(negedge clock);
      if (c == 0) check("bp/in_ready_release", a_in_ready, 1);
      if (c == 1) valid_at1 = a_out_valid;
      if (a_out_valid && a_out_ready) begin
        hs++;
        check("bp/release_sum", a_out_sum, 4);
      end
      next_cycle();
    end
    check("bp/second_next_cycle", valid_at1, 1);
    check("bp/handshakes", hs, 2);

    // Reset mid-vector discards the partial sum and count
    drive(1'b0, 1'b1, 8'd10, 8'd10);
    next_cycle();
    next_cycle();
    drive(1'b0, 1'b0, 8'd0, 8'd0);
    reset_n = 1'b0;
    #1;
    check("rst_mid/out_valid", a_out_valid, 0);
    check("rst_mid/out_sum", a_out_sum, 0);
    check("rst_mid/b_out_sum", b_out_sum, 0);
    check("rst_mid/in_ready", a_in_ready, 1);
    next_cycle();
    reset_n = 1'b1;
    next_cycle();
    run_vec(post_rst);

    // Randomized traffic on the 17-bit instance against an arithmetic model
    max_b = (32'd1 << W_B) - 1;
    remaining = 4 * 60; part = 0; pcnt = 0;
    for (int unsigned c = 0; c < 4000 && (remaining > 0 || q_sum.size() > 0); c++) begin
      if ($urandom_range(0, 1) != 0) begin
        ra = $urandom_range(200, 255); rb = $urandom_range(200, 255);
      end else begin
        ra = $urandom_range(0, 255); rb = $urandom_range(0, 255);
      end
      drive(1'b1, (remaining > 0) && ($urandom_range(0, 3) != 0), 8'(ra), 8'(rb));
      b_out_ready = ($urandom_range(0, 2) != 0);
      @(negedge clock);
      if (b_in_valid && b_in_ready) begin
        part += ra * rb;
        pcnt++;
        remaining--;
        if (pcnt == LEN) begin
          q_ovf.push_back(part > max_b);
          q_sum.push_back((part > max_b) ? (SAT ? max_b : (part & max_b)) : part);
          part = 0;
          pcnt = 0;
        end
      end
      if (b_out_valid && b_out_ready) begin
        check("rnd/result_expected", q_sum.size() != 0, 1);
        if (q_sum.size() != 0) begin
          check("rnd/sum", b_out_sum, q_sum.pop_front());
          check("rnd/ovf", b_out_ovf, q_ovf.pop_front());
        end
      end
      next_cycle();
    end
    check("rnd/drained", q_sum.size(), 0);
    check("rnd/all_sent", remaining, 0);
    b_in_valid = 1'b0;
    b_out_ready = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
